// File: rtl/softreg_if.sv
// SoftReg request/response bundle between a host-side driver (master)
// and an accelerator register port (slave).
interface softreg_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_isWrite;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_isWrite, req_addr, req_data,
        input  resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_isWrite, req_addr, req_data,
        output resp_valid, resp_data
    );
endinterface

// File: rtl/softreg_seq_driver.sv
// Programmable SoftReg command sequencer: runs a small table of WRITE/READ/
// POLL/DELAY commands against a SoftReg port and reports completion or timeout.
module softreg_seq_driver #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int TIMEOUT  = 1024,
    parameter int POLL_GAP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_wr_en,
    input  logic [IDX_W-1:0]  cmd_wr_idx,
    input  logic [1:0]        cmd_wr_op,
    input  logic [ADDR_W-1:0] cmd_wr_addr,
    input  logic [DATA_W-1:0] cmd_wr_data,
    input  logic              start,
    input  logic [IDX_W:0]    cmd_count,
    softreg_if.master         softreg,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  err_idx,
    output logic              resp_strobe,
    output logic [DATA_W-1:0] last_resp_data
);

    localparam logic [IDX_W:0] DEPTH_N = (IDX_W+1)'(DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_POLL, OP_DELAY} op_e;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RESP, S_POLL_GAP, S_DELAY} state_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t table_mem [DEPTH];

    state_e            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W:0]    n_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [31:0]       dly_cnt_reg;
    logic              req_valid_reg;
    logic              req_is_write_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [DATA_W-1:0] req_data_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;
    logic [IDX_W-1:0]  err_idx_reg;
    logic              resp_strobe_reg;
    logic [DATA_W-1:0] last_resp_reg;

    logic              advance;
    logic              relaunch;
    logic              expire;
    logic              resp_take;
    logic              start_ok;
    logic              finish;
    logic              launch;
    logic [IDX_W:0]    start_n;
    logic [IDX_W:0]    next_idx;
    logic [IDX_W-1:0]  launch_idx;
    entry_t            launch_entry;
    logic [31:0]       launch_dly;
    op_e               cur_op;
    logic [DATA_W-1:0] cur_data;

    // Table is frozen while a sequence runs, so the live entry can be read directly.
    always_ff @(posedge clk) begin
        if (cmd_wr_en && !rst && state_reg == S_IDLE && ({1'b0, cmd_wr_idx} < DEPTH_N))
            table_mem[cmd_wr_idx] <= '{op: op_e'(cmd_wr_op), addr: cmd_wr_addr, data: cmd_wr_data};
    end

    assign cur_op       = table_mem[idx_reg].op;
    assign cur_data     = table_mem[idx_reg].data;
    assign start_ok     = start && (state_reg == S_IDLE);
    assign start_n      = (cmd_count > DEPTH_N) ? DEPTH_N : cmd_count;
    assign next_idx     = {1'b0, idx_reg} + (IDX_W+1)'(1);
    assign finish       = advance && (next_idx >= n_reg);
    assign launch       = (start_ok && start_n != '0) || (advance && !finish) || relaunch;
    assign launch_idx   = start_ok ? '0 : (relaunch ? idx_reg : next_idx[IDX_W-1:0]);
    assign launch_entry = table_mem[launch_idx];
    assign launch_dly   = launch_entry.data[31:0];

    always_comb begin
        advance   = 1'b0;
        relaunch  = 1'b0;
        expire    = 1'b0;
        resp_take = 1'b0;
        case (state_reg)
            S_ISSUE:     advance = (cur_op == OP_WRITE);
            S_WAIT_RESP: begin
                // A response in the expiry cycle still counts.
                if (softreg.resp_valid) begin
                    resp_take = 1'b1;
                    advance   = (cur_op == OP_READ) || (softreg.resp_data == cur_data);
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    expire = 1'b1;
                end
            end
            S_POLL_GAP:  relaunch = (gap_cnt_reg == '0);
            S_DELAY:     advance  = (dly_cnt_reg == '0);
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            idx_reg          <= '0;
            n_reg            <= '0;
            tmo_cnt_reg      <= '0;
            gap_cnt_reg      <= '0;
            dly_cnt_reg      <= '0;
            req_valid_reg    <= 1'b0;
            req_is_write_reg <= 1'b0;
            req_addr_reg     <= '0;
            req_data_reg     <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            err_idx_reg      <= '0;
            resp_strobe_reg  <= 1'b0;
            last_resp_reg    <= '0;
        end else begin
            req_valid_reg    <= 1'b0;
            req_is_write_reg <= 1'b0;
            req_addr_reg     <= '0;
            req_data_reg     <= '0;
            done_reg         <= 1'b0;
            resp_strobe_reg  <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        n_reg     <= start_n;
                        error_reg <= 1'b0;
                        done_reg  <= (start_n == '0);
                    end
                end
                S_ISSUE: begin
                    if (cur_op != OP_WRITE) begin
                        state_reg   <= S_WAIT_RESP;
                        tmo_cnt_reg <= TMO_W'(1);
                    end
                end
                S_WAIT_RESP: begin
                    if (resp_take) begin
                        last_resp_reg   <= softreg.resp_data;
                        resp_strobe_reg <= 1'b1;
                        if (!advance) begin
                            state_reg   <= S_POLL_GAP;
                            gap_cnt_reg <= GAP_LOAD;
                        end
                    end else if (expire) begin
                        error_reg   <= 1'b1;
                        err_idx_reg <= idx_reg;
                        busy_reg    <= 1'b0;
                        state_reg   <= S_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end
                S_POLL_GAP: if (gap_cnt_reg != '0) gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                S_DELAY:    if (dly_cnt_reg != '0) dly_cnt_reg <= dly_cnt_reg - 32'd1;
                default:    state_reg <= S_IDLE;
            endcase

            if (finish) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
            end

            // Entering an entry: requests go out on the very next cycle.
            if (launch) begin
                idx_reg     <= launch_idx;
                busy_reg    <= 1'b1;
                tmo_cnt_reg <= '0;
                if (launch_entry.op == OP_DELAY) begin
                    state_reg   <= S_DELAY;
                    dly_cnt_reg <= (launch_dly == '0) ? '0 : launch_dly - 32'd1;
                end else begin
                    state_reg        <= S_ISSUE;
                    req_valid_reg    <= 1'b1;
                    req_is_write_reg <= (launch_entry.op == OP_WRITE);
                    req_addr_reg     <= launch_entry.addr;
                    req_data_reg     <= (launch_entry.op == OP_WRITE) ? launch_entry.data : '0;
                end
            end
        end
    end

    assign softreg.req_valid   = req_valid_reg;
    assign softreg.req_isWrite = req_is_write_reg;
    assign softreg.req_addr    = req_addr_reg;
    assign softreg.req_data    = req_data_reg;
    assign busy                = busy_reg;
    assign done                = done_reg;
    assign error               = error_reg;
    assign err_idx             = err_idx_reg;
    assign resp_strobe         = resp_strobe_reg;
    assign last_resp_data      = last_resp_reg;

endmodule

// File: tb/tb_softreg_seq_driver.sv
// Directed bench for softreg_seq_driver: write/delay timing, read, poll retry,
// timeout, count clamping, and abort by reset.
module tb_softreg_seq_driver;

    localparam logic [1:0] WR = 2'd0, RD = 2'd1, PL = 2'd2, DL = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_wr_en = 1'b0;
    logic [3:0]  cmd_wr_idx = '0;
    logic [1:0]  cmd_wr_op = '0;
    logic [31:0] cmd_wr_addr = '0;
    logic [63:0] cmd_wr_data = '0;
    logic        start = 1'b0;
    logic [4:0]  cmd_count = '0;
    logic        busy, done, error, resp_strobe;
    logic [3:0]  err_idx;
    logic [63:0] last_resp_data;

    int vectors = 0;
    int miscompares = 0;
    int req_seen = 0;
    int done_seen = 0;
    int req_mark, done_mark;

    softreg_if #(.ADDR_W(32), .DATA_W(64)) sr ();

    softreg_seq_driver #(
        .DEPTH(16), .IDX_W(4), .ADDR_W(32), .DATA_W(64), .TIMEOUT(1024), .POLL_GAP(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_wr_en(cmd_wr_en), .cmd_wr_idx(cmd_wr_idx), .cmd_wr_op(cmd_wr_op),
        .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
        .start(start), .cmd_count(cmd_count),
        .softreg(sr.master),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx),
        .resp_strobe(resp_strobe), .last_resp_data(last_resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sr.req_valid) req_seen <= req_seen + 1;
        if (done) done_seen <= done_seen + 1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [1:0] op, input logic [31:0] addr, input logic [63:0] data);
        cmd_wr_en = 1'b1; cmd_wr_idx = idx[3:0]; cmd_wr_op = op;
        cmd_wr_addr = addr; cmd_wr_data = data;
        step();
        cmd_wr_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] cnt);
        start = 1'b1; cmd_count = cnt;
        step();
        start = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic v, input logic w, input logic [31:0] a, input logic [63:0] d);
        chk({tag, "_valid"}, 64'(sr.req_valid), 64'(v));
        if (v) begin
            chk({tag, "_iswr"}, 64'(sr.req_isWrite), 64'(w));
            chk({tag, "_addr"}, 64'(sr.req_addr), 64'(a));
            chk({tag, "_data"}, sr.req_data, d);
        end
    endtask

    initial begin
        sr.resp_valid = 1'b0;
        sr.resp_data  = '0;
        @(negedge clk);
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_req", 64'(sr.req_valid), 64'd0);
        chk("rst_last", last_resp_data, 64'd0);
        rst = 1'b0;
        step();

        // Writes with an interleaved delay: strobes at start+1, +2, +6; done at +7.
        wr(0, WR, 32'h0, 64'd0);
        wr(1, WR, 32'h8, 64'd4);
        wr(2, DL, 32'h0, 64'd3);
        wr(3, WR, 32'h28, 64'd256);
        go(5'd4);
        chk_req("w1", 1'b1, 1'b1, 32'h0, 64'd0);
        chk("w1_busy", 64'(busy), 64'd1);
        step();
        chk_req("w2", 1'b1, 1'b1, 32'h8, 64'd4);
        step(); chk_req("dly3a", 1'b0, 1'b0, 0, 0);
        step(); chk_req("dly4", 1'b0, 1'b0, 0, 0);
        step(); chk_req("dly5", 1'b0, 1'b0, 0, 0);
        chk("dly5_done", 64'(done), 64'd0);
        step(); chk_req("w3", 1'b1, 1'b1, 32'h28, 64'd256);
        chk("w3_done", 64'(done), 64'd0);
        step();
        chk("w_done", 64'(done), 64'd1);
        chk("w_busy", 64'(busy), 64'd0);
        chk_req("w_after", 1'b0, 1'b0, 0, 0);
        step();
        chk("w_done_pulse", 64'(done), 64'd0);

        // READ with response five cycles after the request.
        wr(0, RD, 32'h50, 64'hFFFF);
        go(5'd1);
        chk_req("rd", 1'b1, 1'b0, 32'h50, 64'd0);
        repeat (4) step();
        chk("rd_wait_strobe", 64'(resp_strobe), 64'd0);
        chk("rd_wait_busy", 64'(busy), 64'd1);
        sr.resp_valid = 1'b1; sr.resp_data = 64'h1234;
        step();
        sr.resp_valid = 1'b0; sr.resp_data = '0;
        chk("rd_last", last_resp_data, 64'h1234);
        chk("rd_strobe", 64'(resp_strobe), 64'd1);
        chk("rd_done", 64'(done), 64'd1);
        step();
        chk("rd_strobe_pulse", 64'(resp_strobe), 64'd0);
        sr.resp_valid = 1'b1; sr.resp_data = 64'hDEAD;
        step();
        sr.resp_valid = 1'b0; sr.resp_data = '0;
        chk("idle_resp_last", last_resp_data, 64'h1234);
        chk("idle_resp_strobe", 64'(resp_strobe), 64'd0);

        // POLL expecting 1: responses 0, 0, 1 with 8 idle cycles before each retry.
        wr(0, PL, 32'h50, 64'd1);
        req_mark = req_seen;
        go(5'd1);
        for (int k = 0; k < 3; k++) begin
            chk_req("poll_req", 1'b1, 1'b0, 32'h50, 64'd0);
            step();
            step();
            sr.resp_valid = 1'b1; sr.resp_data = (k == 2) ? 64'd1 : 64'd0;
            step();
            sr.resp_valid = 1'b0; sr.resp_data = '0;
            chk("poll_strobe", 64'(resp_strobe), 64'd1);
            chk("poll_last", last_resp_data, (k == 2) ? 64'd1 : 64'd0);
            if (k < 2) begin
                chk("poll_gap_first", 64'(sr.req_valid), 64'd0);
                repeat (7) step();
                chk("poll_gap_last", 64'(sr.req_valid), 64'd0);
                chk("poll_gap_busy", 64'(busy), 64'd1);
                step();
            end else begin
                chk("poll_done", 64'(done), 64'd1);
                chk("poll_busy", 64'(busy), 64'd0);
            end
        end
        step();
        chk("poll_req_count", 64'(req_seen - req_mark), 64'd3);

        // READ with no responder: error exactly 1024 cycles after the request.
        wr(0, RD, 32'h60, 64'd0);
        done_mark = done_seen;
        go(5'd1);
        chk_req("tmo_req", 1'b1, 1'b0, 32'h60, 64'd0);
        repeat (1023) step();
        chk("tmo_early_err", 64'(error), 64'd0);
        chk("tmo_early_busy", 64'(busy), 64'd1);
        step();
        chk("tmo_err", 64'(error), 64'd1);
        chk("tmo_idx", 64'(err_idx), 64'd0);
        chk("tmo_busy", 64'(busy), 64'd0);
        step();
        chk("tmo_no_done", 64'(done_seen - done_mark), 64'd0);
        chk("tmo_err_sticky", 64'(error), 64'd1);

        // Zero-length start clears the error and completes immediately.
        req_mark = req_seen;
        go(5'd0);
        chk("cnt0_done", 64'(done), 64'd1);
        chk("cnt0_err", 64'(error), 64'd0);
        chk("cnt0_busy", 64'(busy), 64'd0);
        chk("cnt0_req", 64'(sr.req_valid), 64'd0);
        step();
        chk("cnt0_done_pulse", 64'(done), 64'd0);
        chk("cnt0_no_req", 64'(req_seen - req_mark), 64'd0);

        // cmd_count=20 clamps to the 16-entry table.
        for (int i = 0; i < 16; i++) wr(i, WR, 32'(i * 16), 64'(i + 100));
        go(5'd20);
        for (int i = 0; i < 16; i++) begin
            chk_req("clamp", 1'b1, 1'b1, 32'(i * 16), 64'(i + 100));
            chk("clamp_nodone", 64'(done), 64'd0);
            step();
        end
        chk("clamp_done", 64'(done), 64'd1);
        chk("clamp_req_off", 64'(sr.req_valid), 64'd0);

        // Abort a DELAY 100 by reset; writes and starts while busy are ignored.
        wr(0, DL, 32'h0, 64'd100);
        wr(1, WR, 32'h90, 64'd9);
        go(5'd2);
        repeat (4) step();
        chk("abort_busy", 64'(busy), 64'd1);
        cmd_wr_en = 1'b1; cmd_wr_idx = 4'd1; cmd_wr_op = WR;
        cmd_wr_addr = 32'hA0; cmd_wr_data = 64'hAA;
        start = 1'b1; cmd_count = 5'd1;
        step();
        cmd_wr_en = 1'b0; start = 1'b0;
        chk("busy_start_req", 64'(sr.req_valid), 64'd0);
        chk("busy_start_done", 64'(done), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy_off", 64'(busy), 64'd0);
        chk("abort_last", last_resp_data, 64'd0);
        chk("abort_req", 64'(sr.req_valid), 64'd0);
        req_mark = req_seen; done_mark = done_seen;
        repeat (120) step();
        chk("abort_no_req", 64'(req_seen - req_mark), 64'd0);
        chk("abort_no_done", 64'(done_seen - done_mark), 64'd0);
        wr(0, WR, 32'h70, 64'd7);
        go(5'd2);
        chk_req("tbl_e0", 1'b1, 1'b1, 32'h70, 64'd7);
        step();
        chk_req("tbl_e1", 1'b1, 1'b1, 32'h90, 64'd9);
        step();
        chk("tbl_done", 64'(done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
